mem_stage: RTL and testbench

- Pipeline MEM stage, between the EX/MEM boundary and the WB register file write port. Replaces the single-cycle dmem access.
- Accepts one instruction per cycle from EX. Drives a multi-cycle data-memory request/ready handshake and stalls upstream while an access is outstanding.
- Aligns load data and sign/zero-extends it. Forms byte enables and lane-replicated store data.
- Registers the MEM/WB result.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access size codes,
// FSM state encoding and the byte-enable helper.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   // be[0] is the most significant byte lane (bits [0:7]); offset is addr[30:31]
   function automatic logic [0:3] be_for(input logic [1:0] size, input logic [1:0] offset);
      logic [0:3] be;
      case (size)
         SZ_BYTE: be = 4'b1000 >> offset;
         SZ_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
// Big-endian bit numbering: bit 0 is the most significant bit.
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [0:31] addr;
   logic [0:3]  be;
   logic [0:31] wdata;
   logic        ready;
   logic [0:31] rdata;

   modport master (output req, we, addr, be, wdata, input ready, rdata);
   modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// read word, right-justifies it and sign- or zero-extends it.
module load_align
   import mem_pkg::*;
(
   input  logic [0:31] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   output logic [0:31] o_data
);

   logic [0:7]  w_byte;
   logic [0:15] w_half;

   // Lane select then extension; bit 0 of each slice is its sign bit
   always_comb begin
      w_byte = i_rdata[{i_offset, 3'b000} +: 8];
      w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
      case (i_size)
         SZ_BYTE: o_data = {{24{i_sign & w_byte[0]}}, w_byte};
         SZ_HALF: o_data = {{16{i_sign & w_half[0]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: multi-cycle dmem handshake, store lane formation, load
// alignment and the MEM/WB register. MEM_MISALIGN_TRAP_EN drops misaligned accesses.
module mem_stage
   import mem_pkg::*;
#(
   parameter int REG_ADDR_W = 6,
   parameter int XLEN       = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid_i,
   input  logic                  ex_load_i,
   input  logic                  ex_store_i,
   input  logic [1:0]            ex_size_i,
   input  logic                  ex_sign_i,
   input  logic [0:XLEN-1]       ex_addr_i,
   input  logic [0:XLEN-1]       ex_wdata_i,
   input  logic [0:XLEN-1]       ex_result_i,
   input  logic [REG_ADDR_W-1:0] ex_rw_i,
   input  logic                  ex_rwe_i,
   output logic                  stall_o,
   mem_stage_if.master           mem,
   output logic                  wb_valid_o,
   output logic [0:XLEN-1]       wb_data_o,
   output logic [REG_ADDR_W-1:0] wb_rw_o,
   output logic                  wb_rwe_o,
   output logic                  misalign_o
);

   state_t                r_state, w_state_nxt;
   logic [0:29]           r_waddr;
   logic [1:0]            r_off, r_size;
   logic                  r_sign, r_we, r_rwe;
   logic [0:3]            r_be;
   logic [0:XLEN-1]       r_wdata;
   logic [REG_ADDR_W-1:0] r_rw;
   logic                  r_wb_valid, r_wb_rwe, r_misalign;
   logic [0:XLEN-1]       r_wb_data;
   logic [REG_ADDR_W-1:0] r_wb_rw;

   logic                  w_is_mem, w_trap, w_capture;
   logic [1:0]            w_offset;
   logic [0:XLEN-1]       w_wdata_rep, w_load_data;
   logic                  w_wb_valid, w_wb_rwe, w_misalign;
   logic [0:XLEN-1]       w_wb_data;
   logic [REG_ADDR_W-1:0] w_wb_rw;

`ifdef MEM_MISALIGN_TRAP_EN
   // Misalignment detection on the incoming access
   always_comb begin
      case (ex_size_i)
         SZ_BYTE: w_trap = 1'b0;
         SZ_HALF: w_trap = ex_addr_i[31];
         default: w_trap = |ex_addr_i[30:31];
      endcase
   end
`else
   assign w_trap = 1'b0;
`endif

   // Offset forced to natural alignment; store data replicated across lanes
   always_comb begin
      w_is_mem = ex_load_i | ex_store_i;
      case (ex_size_i)
         SZ_BYTE: begin
            w_offset    = ex_addr_i[30:31];
            w_wdata_rep = {4{ex_wdata_i[24:31]}};
         end
         SZ_HALF: begin
            w_offset    = {ex_addr_i[30], 1'b0};
            w_wdata_rep = {2{ex_wdata_i[16:31]}};
         end
         default: begin
            w_offset    = 2'b00;
            w_wdata_rep = ex_wdata_i;
         end
      endcase
   end

   load_align u_load_align (
      .i_rdata  (mem.rdata),
      .i_offset (r_off),
      .i_size   (r_size),
      .i_sign   (r_sign),
      .o_data   (w_load_data)
   );

   // FSM next state and next MEM/WB contents; bubble by default
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_wb_valid  = 1'b0;
      w_wb_rwe    = 1'b0;
      w_wb_data   = r_wb_data;
      w_wb_rw     = r_wb_rw;
      w_misalign  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ex_valid_i && w_is_mem && w_trap) begin
               w_misalign = 1'b1;
            end else if (ex_valid_i && w_is_mem) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ACCESS;
            end else if (ex_valid_i) begin
               w_wb_valid = 1'b1;
               w_wb_data  = ex_result_i;
               w_wb_rw    = ex_rw_i;
               w_wb_rwe   = ex_rwe_i;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (mem.ready) begin
               w_state_nxt = ST_IDLE;
               w_wb_valid  = 1'b1;
               w_wb_rw     = r_rw;
               w_wb_rwe    = r_we ? 1'b0 : r_rwe;
               w_wb_data   = r_we ? {XLEN{1'b0}} : w_load_data;
            end else begin
               w_state_nxt = ST_ACCESS;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Holding registers for the outstanding access (store wins over load)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_waddr <= 30'd0;
         r_off   <= 2'b00;
         r_size  <= 2'b00;
         r_sign  <= 1'b0;
         r_we    <= 1'b0;
         r_rwe   <= 1'b0;
         r_be    <= 4'b0000;
         r_wdata <= {XLEN{1'b0}};
         r_rw    <= {REG_ADDR_W{1'b0}};
      end else if (w_capture) begin
         r_waddr <= ex_addr_i[0:29];
         r_off   <= w_offset;
         r_size  <= ex_size_i;
         r_sign  <= ex_sign_i;
         r_we    <= ex_store_i;
         r_rwe   <= ex_rwe_i;
         r_be    <= be_for(ex_size_i, w_offset);
         r_wdata <= w_wdata_rep;
         r_rw    <= ex_rw_i;
      end
   end

   // MEM/WB register and misalign pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wb_valid <= 1'b0;
         r_wb_rwe   <= 1'b0;
         r_wb_data  <= {XLEN{1'b0}};
         r_wb_rw    <= {REG_ADDR_W{1'b0}};
         r_misalign <= 1'b0;
      end else begin
         r_wb_valid <= w_wb_valid;
         r_wb_rwe   <= w_wb_rwe;
         r_wb_data  <= w_wb_data;
         r_wb_rw    <= w_wb_rw;
         r_misalign <= w_misalign;
      end
   end

   assign stall_o    = (r_state == ST_ACCESS);
   assign mem.req    = (r_state == ST_ACCESS);
   assign mem.we     = r_we;
   assign mem.addr   = {r_waddr, 2'b00};
   assign mem.be     = r_be;
   assign mem.wdata  = r_wdata;
   assign wb_valid_o = r_wb_valid;
   assign wb_rwe_o   = r_wb_rwe;
   assign wb_data_o  = r_wb_data;
   assign wb_rw_o    = r_wb_rw;
   assign misalign_o = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a lane-arithmetic reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_sign = 1'b0, ex_rwe = 1'b0;
   logic [1:0]  ex_size = 2'b00;
   logic [0:31] ex_addr = 32'd0, ex_wdata = 32'd0, ex_result = 32'd0;
   logic [5:0]  ex_rw = 6'd0;
   logic        stall, wb_valid, wb_rwe, misalign;
   logic [0:31] wb_data;
   logic [5:0]  wb_rw;
   int          n_checks = 0;
   int          n_fail = 0;

   mem_stage_if mem_if ();

   mem_stage #(.REG_ADDR_W(6), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .ex_valid_i(ex_valid), .ex_load_i(ex_load), .ex_store_i(ex_store),
      .ex_size_i(ex_size), .ex_sign_i(ex_sign), .ex_addr_i(ex_addr),
      .ex_wdata_i(ex_wdata), .ex_result_i(ex_result), .ex_rw_i(ex_rw), .ex_rwe_i(ex_rwe),
      .stall_o(stall), .mem(mem_if.master),
      .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_rw_o(wb_rw), .wb_rwe_o(wb_rwe),
      .misalign_o(misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One EX instruction, memory responding after 'waits' idle ACCESS cycles
   task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] res,
                        input logic [5:0] rw, input bit rwe, input int waits, input logic [31:0] rd);
      int o, n;
      bit trap;
      logic [31:0] exp_be, exp_wd, exp_ld, mask, v;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      o = int'(addr[1:0]);
      trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap = (n == 2 && (o % 2) != 0) || (n == 4 && o != 0);
`endif
      if (n == 2) o = o - (o % 2);
      else if (n == 4) o = 0;
      exp_be = 32'd0;
      for (int l = o; l < o + n; l++) exp_be |= 32'(8 >> l);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      exp_wd = 32'd0;
      for (int k = 0; k < 4 / n; k++) exp_wd |= (wd & mask) << (8 * n * k);
      v = (rd >> (8 * (4 - o - n))) & mask;
      if (sg && n < 4 && v[8 * n - 1]) v |= ~mask;
      exp_ld = v;

      check("stall_pre", stall, 32'd0);
      ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_size = sz; ex_sign = sg;
      ex_addr = addr; ex_wdata = wd; ex_result = res; ex_rw = rw; ex_rwe = rwe;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      if (!(ld || st)) begin
         check("alu_valid", wb_valid, 32'd1);
         check("alu_data", wb_data, res);
         check("alu_rw", wb_rw, rw);
         check("alu_rwe", wb_rwe, rwe);
         check("alu_stall", stall, 32'd0);
         check("alu_req", mem_if.req, 32'd0);
      end else if (trap) begin
         check("trap_req", mem_if.req, 32'd0);
         check("trap_stall", stall, 32'd0);
         check("trap_pulse", misalign, 32'd1);
         check("trap_wbv", wb_valid, 32'd0);
         @(posedge clk); #1;
         check("trap_pulse_end", misalign, 32'd0);
      end else begin
         check("acc_req", mem_if.req, 32'd1);
         check("acc_we", mem_if.we, st);
         check("acc_addr", mem_if.addr, {addr[31:2], 2'b00});
         check("acc_be", mem_if.be, exp_be);
         if (st) check("acc_wdata", mem_if.wdata, exp_wd);
         check("acc_wbv", wb_valid, 32'd0);
         check("acc_misal", misalign, 32'd0);
         for (int w = 0; w < waits; w++) begin
            check("wait_stall", stall, 32'd1);
            @(posedge clk); #1;
            check("wait_req", mem_if.req, 32'd1);
            check("wait_be", mem_if.be, exp_be);
            check("wait_wbv", wb_valid, 32'd0);
         end
         check("last_stall", stall, 32'd1);
         mem_if.ready = 1'b1;
         mem_if.rdata = rd;
         @(posedge clk); #1;
         mem_if.ready = 1'b0;
         mem_if.rdata = $urandom;
         check("done_stall", stall, 32'd0);
         check("done_req", mem_if.req, 32'd0);
         check("done_valid", wb_valid, 32'd1);
         check("done_rw", wb_rw, rw);
         check("done_rwe", wb_rwe, st ? 1'b0 : rwe);
         if (!st) check("load_data", wb_data, exp_ld);
      end
   endtask

   initial begin
      mem_if.ready = 1'b0;
      mem_if.rdata = 32'd0;
      #1;
      check("rst_wbv", wb_valid, 32'd0);
      check("rst_rwe", wb_rwe, 32'd0);
      check("rst_data", wb_data, 32'd0);
      check("rst_rw", wb_rw, 32'd0);
      check("rst_req", mem_if.req, 32'd0);
      check("rst_misal", misalign, 32'd0);
      check("rst_stall", stall, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed cases
      do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_002A, 6'd5, 1'b1, 0, 32'h0);
      do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'h0, 32'h0, 6'd7, 1'b1, 3, 32'h1280_3456);
      do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 6'd8, 1'b1, 0, 32'hABCD_8001);
      do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h0, 6'd8, 1'b1, 1, 32'hABCD_8001);
      do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00EE, 32'h0, 6'd9, 1'b1, 0, 32'h0);
      do_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 32'h0, 6'd3, 1'b1, 2, 32'h0);
      do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 6'd4, 1'b1, 0, 32'hCAFE_F00D);
      do_op(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 6'd2, 1'b1, 0, 32'h8765_4321);

      // Reset in the second ACCESS cycle of a word load
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'b10;
      ex_addr = 32'h0000_0100; ex_rw = 6'd11; ex_rwe = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_req_before", mem_if.req, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_req", mem_if.req, 32'd0);
      check("mid_rst_wbv", wb_valid, 32'd0);
      check("mid_rst_stall", stall, 32'd0);
      reset = 1'b0;
      mem_if.ready = 1'b1;
      mem_if.rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      mem_if.ready = 1'b0;
      check("late_ready_wbv", wb_valid, 32'd0);
      check("late_ready_req", mem_if.req, 32'd0);
      do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 6'd12, 1'b1, 0, 32'h0);

      // Randomized traffic with occasional bubbles
      for (int i = 0; i < 200; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            check("bubble_wbv", wb_valid, 32'd0);
            check("bubble_rwe", wb_rwe, 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
